rst_seq_multi: RTL and testbench



---
 rtl/rst_seq_multi.sv | 172 +++++++++++++++++
 tb/tb_rst_seq_multi.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_multi.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_multi
// Description : Multi-channel reset sequencer. Holds every channel asserted,
//               releases each one at its own offset, and optionally repeats.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_seq_multi #(
    parameter int                NUM_CH     = 4,
    parameter int                CNT_W      = 16,
    parameter int                ITER_W     = 8,
    parameter logic [NUM_CH-1:0] POL_MASK   = 4'b0011,
    parameter bit                AUTO_START = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [CNT_W-1:0]        hold_cycles_i,
    input  logic [NUM_CH*CNT_W-1:0] rel_offset_i,
    input  logic [CNT_W-1:0]        run_cycles_i,
    input  logic [ITER_W-1:0]       repeat_i,
    output logic [NUM_CH-1:0]       rst_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [ITER_W-1:0]       iter_o,
    output logic [1:0]              state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_REL  = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ITER_W-1:0] ITER_ONE = {{(ITER_W-1){1'b0}}, 1'b1};

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ITER_W-1:0]         iter_q, iter_d;
    logic [NUM_CH-1:0]         a_q, a_d;
    logic [NUM_CH-1:0]         rst_q;
    logic                      busy_q;
    logic                      done_q, done_d;

    logic [CNT_W-1:0]          hold_q;
    logic [NUM_CH*CNT_W-1:0]   off_q;
    logic [CNT_W-1:0]          run_q;
    logic [ITER_W-1:0]         rep_q;
    logic                      load_cfg;

    logic [CNT_W-1:0]          cnt_inc;
    logic [ITER_W-1:0]         iter_inc;
    logic [CNT_W-1:0]          hold_last;
    logic [CNT_W-1:0]          run_last;
    logic [ITER_W-1:0]         rep_eff;

    // Both counters saturate rather than wrap.
    assign cnt_inc   = (&cnt_q)  ? cnt_q  : cnt_q + CNT_ONE;
    assign iter_inc  = (&iter_q) ? iter_q : iter_q + ITER_ONE;
    assign hold_last = (hold_q == '0) ? '0 : hold_q - CNT_ONE;
    assign run_last  = run_q - CNT_ONE;
    assign rep_eff   = (rep_q == '0) ? ITER_ONE : rep_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        iter_d   = iter_q;
        a_d      = a_q;
        load_cfg = 1'b0;

        case (state_q)
            ST_IDLE: begin
                a_d = '1;
                if (AUTO_START) begin
                    state_d  = ST_HOLD;
                    cnt_d    = '0;
                    load_cfg = 1'b1;
                end
            end
            ST_HOLD: begin
                a_d = '1;
                if (cnt_q == hold_last) begin
                    state_d = ST_REL;
                    cnt_d   = '0;
                    for (int c = 0; c < NUM_CH; c++) begin
                        a_d[c] = (off_q[c*CNT_W +: CNT_W] != '0);
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_REL: begin
                // a_d is computed against the upcoming count so the flopped output lands on cnt == offset.
                if (a_q == '0) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    iter_d  = iter_inc;
                end else begin
                    cnt_d = cnt_inc;
                    for (int c = 0; c < NUM_CH; c++) begin
                        a_d[c] = a_q[c] & (off_q[c*CNT_W +: CNT_W] != cnt_inc);
                    end
                end
            end
            ST_RUN: begin
                a_d = '0;
                if ((run_q != '0) && (cnt_q == run_last) && (iter_q < rep_eff)) begin
                    state_d  = ST_HOLD;
                    cnt_d    = '0;
                    a_d      = '1;
                    load_cfg = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                a_d     = '1;
            end
        endcase

        if (start_i) begin
            state_d  = ST_HOLD;
            cnt_d    = '0;
            iter_d   = '0;
            a_d      = '1;
            load_cfg = 1'b1;
        end

        done_d = (state_d == ST_RUN) && ((run_q == '0) || (iter_d >= rep_eff));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            iter_q  <= '0;
            a_q     <= '1;
            rst_q   <= ~POL_MASK;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= '0;
            off_q   <= '0;
            run_q   <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            iter_q  <= iter_d;
            a_q     <= a_d;
            rst_q   <= a_d ^ POL_MASK;
            busy_q  <= (state_d == ST_HOLD) || (state_d == ST_REL);
            done_q  <= done_d;
            if (load_cfg) begin
                hold_q <= hold_cycles_i;
                off_q  <= rel_offset_i;
                run_q  <= run_cycles_i;
                rep_q  <= repeat_i;
            end
        end
    end

    assign rst_o   = rst_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign iter_o  = iter_q;
    assign state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_rst_seq_multi
// Description : Bench for rst_seq_multi; auto-start and manual-start instances
//               share stimulus and are checked against a sequence-timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_seq_multi;

    localparam logic [3:0] POL = 4'b0011;

    logic        clk = 1'b0;
    logic        rst_i, start_i;
    logic [15:0] hold_i, run_i;
    logic [63:0] off_i;
    logic [7:0]  rep_i;

    logic [3:0]  a_rst, m_rst;
    logic        a_busy, m_busy, a_done, m_done;
    logic [7:0]  a_iter, m_iter;
    logic [1:0]  a_state, m_state;

    int n_cmp = 0;
    int n_bad = 0;

    // Per-instance model: idle flag, cycles since HOLD entry, completed
    // sequences before this one, and the configuration captured at entry.
    bit m_idle [2];
    int m_p    [2];
    int m_k    [2];
    int m_hold [2];
    int m_run  [2];
    int m_rep  [2];
    int m_off  [2][4];

    always #5 clk = ~clk;

    rst_seq_multi #(.NUM_CH(4), .CNT_W(16), .ITER_W(8), .POL_MASK(4'b0011), .AUTO_START(1'b1)) u_auto (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .hold_cycles_i(hold_i),
        .rel_offset_i(off_i), .run_cycles_i(run_i), .repeat_i(rep_i),
        .rst_o(a_rst), .busy_o(a_busy), .done_o(a_done), .iter_o(a_iter), .state_o(a_state));

    rst_seq_multi #(.NUM_CH(4), .CNT_W(16), .ITER_W(8), .POL_MASK(4'b0011), .AUTO_START(1'b0)) u_man (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .hold_cycles_i(hold_i),
        .rel_offset_i(off_i), .run_cycles_i(run_i), .repeat_i(rep_i),
        .rst_o(m_rst), .busy_o(m_busy), .done_o(m_done), .iter_o(m_iter), .state_o(m_state));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int eff1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int max_off(input int d);
        int m = 0;
        for (int c = 0; c < 4; c++) if (m_off[d][c] > m) m = m_off[d][c];
        return m;
    endfunction

    task automatic model_expect(input int d, output logic [3:0] e_rst, output logic e_busy,
                                output logic e_done, output logic [7:0] e_iter, output logic [1:0] e_st);
        logic [3:0] a;
        int he, rl, q;
        a = 4'hF; e_done = 1'b0; e_iter = 8'd0; e_st = 2'd0;
        if (!m_idle[d]) begin
            he = eff1(m_hold[d]);
            rl = max_off(d) + 1;
            q  = m_p[d];
            if (q < he) begin
                e_st = 2'd1; e_iter = 8'(m_k[d]);
            end else if (q < he + rl) begin
                e_st = 2'd2; e_iter = 8'(m_k[d]);
                for (int c = 0; c < 4; c++) a[c] = ((q - he) < m_off[d][c]);
            end else begin
                e_st = 2'd3; a = 4'h0; e_iter = 8'(m_k[d] + 1);
                e_done = (m_run[d] == 0) || (m_k[d] + 1 >= eff1(m_rep[d]));
            end
        end
        e_busy = (e_st == 2'd1) || (e_st == 2'd2);
        e_rst  = a ^ POL;
    endtask

    task automatic model_enter(input int d, input int k);
        m_idle[d] = 1'b0; m_p[d] = 0; m_k[d] = k;
        m_hold[d] = int'(hold_i); m_run[d] = int'(run_i); m_rep[d] = int'(rep_i);
        for (int c = 0; c < 4; c++) m_off[d][c] = int'(off_i[c*16 +: 16]);
    endtask

    function automatic bit seq_end(input int d);
        int he, rl;
        he = eff1(m_hold[d]);
        rl = max_off(d) + 1;
        return (m_run[d] != 0) && (m_p[d] == he + rl + m_run[d] - 1) && (m_k[d] + 1 < eff1(m_rep[d]));
    endfunction

    // Applies the inputs present at the coming clock edge to the model.
    task automatic model_advance();
        for (int d = 0; d < 2; d++) begin
            if (rst_i)                                m_idle[d] = 1'b1;
            else if (m_idle[d]) begin
                if (d == 0 || start_i)                model_enter(d, 0);
            end
            else if (start_i)                         model_enter(d, 0);
            else if (seq_end(d))                      model_enter(d, m_k[d] + 1);
            else                                      m_p[d]++;
        end
    endtask

    task automatic check_all();
        logic [3:0] e_rst, o_rst;
        logic e_busy, e_done, o_busy, o_done;
        logic [7:0] e_iter, o_iter;
        logic [1:0] e_st, o_st;
        for (int d = 0; d < 2; d++) begin
            model_expect(d, e_rst, e_busy, e_done, e_iter, e_st);
            if (d == 0) begin o_rst = a_rst; o_busy = a_busy; o_done = a_done; o_iter = a_iter; o_st = a_state; end
            else        begin o_rst = m_rst; o_busy = m_busy; o_done = m_done; o_iter = m_iter; o_st = m_state; end
            check_val($sformatf("d%0d.state", d), 32'(o_st),   32'(e_st));
            check_val($sformatf("d%0d.rst_o", d), 32'(o_rst),  32'(e_rst));
            check_val($sformatf("d%0d.busy",  d), 32'(o_busy), 32'(e_busy));
            check_val($sformatf("d%0d.done",  d), 32'(o_done), 32'(e_done));
            check_val($sformatf("d%0d.iter",  d), 32'(o_iter), 32'(e_iter));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int h, input int o0, input int o1, input int o2, input int o3,
                           input int r, input int rp);
        hold_i = 16'(h);
        off_i  = {16'(o3), 16'(o2), 16'(o1), 16'(o0)};
        run_i  = 16'(r);
        rep_i  = 8'(rp);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0;
        set_cfg(5, 0, 2, 2, 7, 0, 1);
        for (int d = 0; d < 2; d++) begin m_idle[d] = 1'b1; m_p[d] = 0; m_k[d] = 0; end
        @(posedge clk); #1;

        // Reset values held over three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("rst.rst_o", 32'(a_rst), 32'hC);
            check_val("rst.state", 32'(a_state), 32'h0);
        end

        // Auto-start timeline; manual instance must idle without start_i.
        rst_i = 1'b0;
        for (int t = 1; t <= 100; t++) begin
            tick();
            if (t == 5)  check_val("tp1.c5_hold",  32'(a_state), 32'h1);
            if (t == 6)  check_val("tp1.c6_rst",   32'(a_rst),   32'hD);
            if (t == 8)  check_val("tp1.c8_rst",   32'(a_rst),   32'hB);
            if (t == 13) check_val("tp1.c13_rst",  32'(a_rst),   32'h3);
            if (t == 14) check_val("tp1.c14_st",   32'(a_state), 32'h3);
            if (t == 14) check_val("tp1.c14_done", 32'(a_done),  32'h1);
        end
        check_val("man.idle_state", 32'(m_state), 32'h0);
        check_val("man.idle_rst",   32'(m_rst),   32'hC);
        pulse_start();
        check_val("man.start_hold", 32'(m_state), 32'h1);

        // Repeat three times.
        set_cfg(2, 1, 1, 1, 1, 4, 3);
        pulse_start();
        for (int i = 0; i < 40; i++) tick();
        check_val("rep.iter",  32'(m_iter),  32'h3);
        check_val("rep.state", 32'(m_state), 32'h3);
        check_val("rep.done",  32'(m_done),  32'h1);

        // Restart in the middle of RELEASE with a new configuration.
        set_cfg(3, 0, 10, 10, 10, 2, 1);
        pulse_start();
        for (int i = 0; i < 7; i++) tick();
        set_cfg(4, 2, 2, 2, 2, 0, 1);
        pulse_start();
        check_val("mid.rst_o", 32'(m_rst),  32'hC);
        check_val("mid.iter",  32'(m_iter), 32'h0);
        for (int i = 0; i < 20; i++) tick();

        // Config change during HOLD is ignored; hold of zero acts as one.
        set_cfg(5, 1, 0, 3, 2, 3, 2);
        pulse_start();
        tick();
        hold_i = 16'd50;
        for (int i = 0; i < 30; i++) tick();
        set_cfg(0, 0, 0, 0, 0, 1, 2);
        pulse_start();
        for (int i = 0; i < 15; i++) tick();

        // Reset wins over start.
        rst_i = 1'b1; start_i = 1'b1;
        tick();
        rst_i = 1'b0; start_i = 1'b0;
        check_val("rst_vs_start", 32'(m_state), 32'h0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)
                set_cfg($urandom_range(0, 6), $urandom_range(0, 9), $urandom_range(0, 9),
                        $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 6),
                        $urandom_range(0, 3));
            start_i = ($urandom_range(0, 39) == 0);
            rst_i   = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst_i = 1'b0; start_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
